axi_trace_buffer: RTL and testbench
===================================

Name: axi_trace_buffer

Overview:
Parametrised, synthesizable capture buffer for AXI debug tap events, generalising the per-channel debug valid/address/data taps into an on-chip trace store. It records NUM_CH event channels (default AR, R, AW, W) into a shared circular buffer, with a channel ID and an optional cycle timestamp per record. Records are drained through a valid/ready stream, so a testbench monitor or a debug peripheral can read them without a simulator $write.

Parameters:
NUM_CH, 4, number of event channels; 1..8; ID width = max(1,$clog2(NUM_CH))
DATA_W, 32, payload width per channel (address or data word)
DEPTH, 16, buffer entries; power of two, >= 2
TS_W, 16, timestamp width (used only with timestamps enabled)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
enable_i  in  1  capture enable; when low, new events are ignored and not counted
wrap_mode_i  in  1  0 = stop when full, 1 = overwrite oldest when full
clear_i  in  1  synchronous flush of buffer, pending registers and counters
ev_valid_i  in  NUM_CH  per-channel event strobe (one cycle per event)
ev_data_i  in  NUM_CH*DATA_W  per-channel payload; channel c is bits [c*DATA_W +: DATA_W]
rd_valid_o  out  1  record available
rd_ready_i  in  1  consumer accepts record
rd_ch_o  out  ID_W  channel of head record
rd_data_o  out  DATA_W  payload of head record
rd_ts_o  out  TS_W  timestamp of head record
count_o  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
drop_cnt_o  out  16  events lost to a busy pending slot; saturates at 0xFFFF
wrapped_o  out  1  sticky; set on the first overwrite in wrap mode

Behaviour:
- Reset, and clear_i: all outputs 0; pointers, count, pending flags, drop_cnt and wrapped are 0; round-robin pointer is 0. The timestamp counter is cleared by reset only; clear_i leaves it running.
- Timestamp counter: free-running, +1 per cycle, wraps modulo 2^TS_W.
- Per-channel pending register. If enable_i and ev_valid_i[c] are high in cycle N, pend[c] is set at the end of cycle N and latches the data and the timestamp of cycle N.
- If pend[c] is already set and is not granted in cycle N, the new event is dropped and drop_cnt increments. If pend[c] is granted in cycle N, the new event is accepted.
- Multiple channels dropping in the same cycle add the number of drops, saturating.
- Arbiter: round-robin over pend[]; at most one grant per cycle. The search starts at rr_ptr; after a grant, rr_ptr = granted+1 mod NUM_CH.
- A grant is allowed when count < DEPTH, or when wrap_mode_i = 1.
- A grant writes {ch, data, ts} to the buffer at the clock edge ending that cycle and clears that pending flag.
- Latency: event in cycle N, grant in cycle N+1, rd_valid_o high in cycle N+2 when the buffer was empty and there is no contention.
- Read is first-word-fall-through: rd_valid_o = (count != 0), rd_* show the head entry, and a pop occurs when rd_valid_o && rd_ready_i.
- Full in stop mode: no grant, pending flags hold, later events on busy channels are dropped.
- Full in wrap mode, no pop: the write overwrites the oldest entry, the read pointer advances, count stays DEPTH and wrapped_o is set.
- Full with a pop and a write in the same cycle (either mode): normal write and pop, no overwrite, count unchanged.
- Empty with a write and rd_ready_i high in the same cycle: no pop, because rd_valid_o is still 0; count becomes 1.
- clear_i in the same cycle as events: clear wins and those events are discarded.
- Reset mid-stream: everything is discarded; rd_valid_o is 0 the cycle after reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally; count is tracked separately.

Optional Feature:
Macro AXI_TRACE_TIMESTAMP_EN.
- Defined: the counter and the per-record TS_W storage exist, and rd_ts_o carries the capture-cycle timestamp.
- Not defined: no counter or storage; rd_ts_o is tied to 0, and records are {ch, data} only.

Decomposition:
- Package axi_trace_pkg: ID_W and PTR_W functions, the trace_rec_t packed struct (ch, data, ts under the macro), and the drop counter width constant (16).
- Sub-module axi_trace_fifo: synchronous FWFT buffer with push/pop/overwrite, count and a wrapped flag. The top level holds the pending registers, arbiter, timestamp counter and drop counter.

Test Plan:
- Single event: ch2 pulse with data 0xDEAD_BEEF at ts=5 -> cycle+2 rd_valid=1, rd_ch=2, rd_data=0xDEADBEEF, rd_ts=5; pop -> count=0.
- Simultaneous events: all 4 channels valid in one cycle, data 0x10..0x13 -> four records in channel order 0,1,2,3 on consecutive cycles; drop_cnt=0.
- Drop: ch0 pulsed 3 consecutive cycles while ch1..3 are pending -> ch0 records as many events as it was granted, drop_cnt equals lost events; the check holds with exact counts on a reference model.
- Stop mode: wrap_mode=0, DEPTH=16, 20 events on ch1 with rd_ready=0 -> count=16, records 0..15 retained, wrapped_o=0, pending slot plus drops account for the remaining 4.
- Wrap mode: wrap_mode=1, 20 events with data 0..19, no reads -> count=16, wrapped_o=1, drained data 4..19 in order.
- clear_i with the buffer at count=7 and events in flight -> next cycle count=0, rd_valid=0, drop_cnt=0; the timestamp keeps incrementing.

Source files
------------

// File: rtl/axi_trace_pkg.sv
// Shared sizing helpers and record layout for the AXI trace buffer.
// The record carries a timestamp field only when AXI_TRACE_TIMESTAMP_EN is defined.
package axi_trace_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_TS_W   = 16;
  localparam int DROP_W     = 16;

  function automatic int calcIdW(input int numCh);
    return (numCh > 1) ? $clog2(numCh) : 1;
  endfunction

  function automatic int calcPtrW(input int depth);
    return $clog2(depth);
  endfunction

  // Record layout for the default configuration.
  typedef struct packed {
    logic [calcIdW(DEF_NUM_CH)-1:0] ch;
    logic [DEF_DATA_W-1:0]          data;
`ifdef AXI_TRACE_TIMESTAMP_EN
    logic [DEF_TS_W-1:0]            ts;
`endif
  } trace_rec_t;

endpackage

// File: rtl/axi_trace_fifo.sv
// First-word-fall-through record store; a push into a full store without a pop
// overwrites the oldest entry and sets the sticky wrapped flag.
module axi_trace_fifo
  import axi_trace_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [calcPtrW(DEPTH):0] count_o,
  output logic                     wrapped_o
);

  localparam int PtrW = calcPtrW(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wrPtr_q, wrPtr_d;
  logic [PtrW-1:0]  rdPtr_q, rdPtr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             wrapped_q, wrapped_d;
  logic             pop, full, overwrite;

  assign valid_o   = (count_q != '0);
  assign pop       = valid_o && ready_i;
  assign full      = (count_q == (PtrW+1)'(DEPTH));
  assign overwrite = push_i && full && !pop;
  assign rdata_o   = valid_o ? mem_q[rdPtr_q] : '0;
  assign count_o   = count_q;
  assign wrapped_o = wrapped_q;

  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    wrapped_d = wrapped_q;
    if (push_i) wrPtr_d = wrPtr_q + PtrW'(1);
    if (pop || overwrite) rdPtr_d = rdPtr_q + PtrW'(1);
    // Overwrite moves both pointers together, so occupancy stays at DEPTH.
    if (overwrite) wrapped_d = 1'b1;
    else if (push_i && !pop) count_d = count_q + (PtrW+1)'(1);
    else if (pop && !push_i) count_d = count_q - (PtrW+1)'(1);
    if (clear_i) begin
      wrPtr_d   = '0;
      rdPtr_d   = '0;
      count_d   = '0;
      wrapped_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      wrapped_q <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i && !rst_i) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/axi_trace_buffer.sv
// Multi-channel AXI debug event capture into a shared circular trace store.
// Define AXI_TRACE_TIMESTAMP_EN to add a free-running cycle timestamp to each record.
module axi_trace_buffer
  import axi_trace_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int TS_W   = DEF_TS_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic                       wrap_mode_i,
  input  logic                       clear_i,
  input  logic [NUM_CH-1:0]          ev_valid_i,
  input  logic [NUM_CH*DATA_W-1:0]   ev_data_i,
  output logic                       rd_valid_o,
  input  logic                       rd_ready_i,
  output logic [calcIdW(NUM_CH)-1:0] rd_ch_o,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic [TS_W-1:0]            rd_ts_o,
  output logic [calcPtrW(DEPTH):0]   count_o,
  output logic [DROP_W-1:0]          drop_cnt_o,
  output logic                       wrapped_o
);

  localparam int IdW  = calcIdW(NUM_CH);
  localparam int CntW = calcPtrW(DEPTH) + 1;

  typedef struct packed {
    logic [IdW-1:0]    ch;
    logic [DATA_W-1:0] data;
`ifdef AXI_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
  } rec_t;

  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [DATA_W-1:0] pendData_q [NUM_CH];
  logic [DATA_W-1:0] pendData_d [NUM_CH];
  logic [IdW-1:0]    rr_q, rr_d;
  logic [IdW-1:0]    gntIdx;
  logic              gntValid;
  logic [IdW:0]      drops;
  logic [DROP_W:0]   dropSum;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [CntW-1:0]   count;
  int                bestDist;
  rec_t              wrRec, rdRec;

`ifdef AXI_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] pendTs_q [NUM_CH];
  logic [TS_W-1:0] pendTs_d [NUM_CH];

  // Reset-only counter: a trace flush must not disturb the time base.
  always_ff @(posedge clk_i) begin
    if (rst_i) ts_q <= '0;
    else       ts_q <= ts_q + TS_W'(1);
  end
`endif

  // Round-robin: the pending channel with the smallest distance from rr_q wins.
  always_comb begin
    gntValid = 1'b0;
    gntIdx   = '0;
    bestDist = NUM_CH;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pend_q[c] && (((c + NUM_CH - int'(rr_q)) % NUM_CH) < bestDist)) begin
        bestDist = (c + NUM_CH - int'(rr_q)) % NUM_CH;
        gntIdx   = IdW'(c);
        gntValid = 1'b1;
      end
    end
    if (!((count < CntW'(DEPTH)) || wrap_mode_i)) gntValid = 1'b0;
    rr_d = rr_q;
    if (gntValid) rr_d = (int'(gntIdx) == NUM_CH - 1) ? '0 : gntIdx + IdW'(1);
  end

  always_comb begin
    pend_d     = pend_q;
    pendData_d = pendData_q;
`ifdef AXI_TRACE_TIMESTAMP_EN
    pendTs_d   = pendTs_q;
`endif
    drops      = '0;
    if (gntValid) pend_d[gntIdx] = 1'b0;
    // A slot freed by this cycle's grant can take the new event immediately.
    for (int c = 0; c < NUM_CH; c++) begin
      if (enable_i && ev_valid_i[c]) begin
        if (pend_q[c] && !(gntValid && gntIdx == IdW'(c))) begin
          drops = drops + (IdW+1)'(1);
        end else begin
          pend_d[c]     = 1'b1;
          pendData_d[c] = ev_data_i[c*DATA_W +: DATA_W];
`ifdef AXI_TRACE_TIMESTAMP_EN
          pendTs_d[c]   = ts_q;
`endif
        end
      end
    end
    dropSum = {1'b0, drop_q} + (DROP_W+1)'(drops);
    drop_d  = dropSum[DROP_W] ? '1 : dropSum[DROP_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      pend_q <= '0;
      rr_q   <= '0;
      drop_q <= '0;
    end else begin
      pend_q <= pend_d;
      rr_q   <= rr_d;
      drop_q <= drop_d;
    end
  end

  // Payload slots are only read while their pending flag is set.
  always_ff @(posedge clk_i) begin
    pendData_q <= pendData_d;
`ifdef AXI_TRACE_TIMESTAMP_EN
    pendTs_q   <= pendTs_d;
`endif
  end

  always_comb begin
    wrRec.ch   = gntIdx;
    wrRec.data = pendData_q[gntIdx];
`ifdef AXI_TRACE_TIMESTAMP_EN
    wrRec.ts   = pendTs_q[gntIdx];
`endif
  end

  axi_trace_fifo #(
    .WIDTH($bits(rec_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (clear_i),
    .push_i   (gntValid && !clear_i),
    .wdata_i  (wrRec),
    .ready_i  (rd_ready_i),
    .valid_o  (rd_valid_o),
    .rdata_o  (rdRec),
    .count_o  (count),
    .wrapped_o(wrapped_o)
  );

  assign rd_ch_o    = rdRec.ch;
  assign rd_data_o  = rdRec.data;
  assign count_o    = count;
  assign drop_cnt_o = drop_q;
`ifdef AXI_TRACE_TIMESTAMP_EN
  assign rd_ts_o    = rdRec.ts;
`else
  assign rd_ts_o    = '0;
`endif

endmodule

// File: tb/tb_axi_trace_buffer.sv
// Directed bench for axi_trace_buffer with a queue-based reference model checked every cycle.
// Timestamp expectations follow AXI_TRACE_TIMESTAMP_EN.
module tb_axi_trace_buffer;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 16;

  logic                     clk = 1'b0;
  logic                     rst, enable, wrapMode, clear, rdReady;
  logic [NUM_CH-1:0]        evValid;
  logic [NUM_CH*DATA_W-1:0] evData;
  logic                     rdValid;
  logic [1:0]               rdCh;
  logic [DATA_W-1:0]        rdData;
  logic [TS_W-1:0]          rdTs;
  logic [4:0]               count;
  logic [15:0]              dropCnt;
  logic                     wrapped;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int                ch;
    logic [DATA_W-1:0] data;
    int                ts;
  } modelRec_t;

  modelRec_t         mq[$];
  modelRec_t         mRec;
  bit                mPend [NUM_CH];
  logic [DATA_W-1:0] mPendData [NUM_CH];
  int                mPendTs [NUM_CH];
  int                mRr, mDrop, mTs, mGnt;
  bit                mWrapped, mPop;
  bit                modelLive = 1'b0;

  always #5 clk = ~clk;

  axi_trace_buffer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .enable_i   (enable),
    .wrap_mode_i(wrapMode),
    .clear_i    (clear),
    .ev_valid_i (evValid),
    .ev_data_i  (evData),
    .rd_valid_o (rdValid),
    .rd_ready_i (rdReady),
    .rd_ch_o    (rdCh),
    .rd_data_o  (rdData),
    .rd_ts_o    (rdTs),
    .count_o    (count),
    .drop_cnt_o (dropCnt),
    .wrapped_o  (wrapped)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [NUM_CH*DATA_W-1:0] packData(input logic [31:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [NUM_CH-1:0] v, input logic [NUM_CH*DATA_W-1:0] d);
    evValid = v;
    evData  = d;
    tick(1);
    evValid = '0;
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  function automatic int expTs(input int ts);
`ifdef AXI_TRACE_TIMESTAMP_EN
    return ts;
`else
    return 0 * ts;
`endif
  endfunction

  // Reference model: pending slots, a record queue and round-robin order from the rules.
  always @(posedge clk) begin
    modelLive = 1'b1;
    if (rst || clear) begin
      mq.delete();
      for (int c = 0; c < NUM_CH; c++) mPend[c] = 1'b0;
      mRr = 0;
      mDrop = 0;
      mWrapped = 1'b0;
      mTs = rst ? 0 : (mTs + 1) % 65536;
    end else begin
      mPop = (mq.size() != 0) && rdReady;
      mGnt = -1;
      if (mq.size() < DEPTH || wrapMode)
        for (int k = 0; k < NUM_CH; k++)
          if (mGnt < 0 && mPend[(mRr + k) % NUM_CH]) mGnt = (mRr + k) % NUM_CH;
      if (mPop) void'(mq.pop_front());
      if (mGnt >= 0) begin
        if (mq.size() == DEPTH) begin
          void'(mq.pop_front());
          mWrapped = 1'b1;
        end
        mRec.ch   = mGnt;
        mRec.data = mPendData[mGnt];
        mRec.ts   = mPendTs[mGnt];
        mq.push_back(mRec);
        mPend[mGnt] = 1'b0;
        mRr = (mGnt + 1) % NUM_CH;
      end
      if (enable)
        for (int c = 0; c < NUM_CH; c++)
          if (evValid[c]) begin
            if (mPend[c]) mDrop++;
            else begin
              mPend[c]     = 1'b1;
              mPendData[c] = evData[c*DATA_W +: DATA_W];
              mPendTs[c]   = mTs;
            end
          end
      if (mDrop > 65535) mDrop = 65535;
      mTs = (mTs + 1) % 65536;
    end
  end

  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("model rd_valid", rdValid, mq.size() != 0);
      checkOutput("model count", count, mq.size());
      checkOutput("model drop_cnt", dropCnt, mDrop);
      checkOutput("model wrapped", wrapped, mWrapped);
      if (mq.size() != 0) begin
        checkOutput("model rd_ch", rdCh, mq[0].ch);
        checkOutput("model rd_data", rdData, mq[0].data);
        checkOutput("model rd_ts", rdTs, expTs(mq[0].ts));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; enable = 1'b1; wrapMode = 1'b0; clear = 1'b0; rdReady = 1'b0;
    evValid = '0; evData = '0;
    tick(3);
    checkOutput("reset rd_valid", rdValid, 0);
    checkOutput("reset count", count, 0);
    checkOutput("reset drop_cnt", dropCnt, 0);
    checkOutput("reset wrapped", wrapped, 0);
    checkOutput("reset rd_ts", rdTs, 0);
    rst = 1'b0;

    // Single event on ch2 at timestamp 5, consumer already ready.
    for (int i = 0; i < 20 && mTs != 5; i++) tick(1);
    checkOutput("t1 ts reached", mTs, 5);
    rdReady = 1'b1;
    applyStimulus(4'b0100, packData(0, 0, 32'hDEADBEEF, 0));
    checkOutput("t1 not early", rdValid, 0);
    tick(1);
    checkOutput("t1 rd_valid", rdValid, 1);
    checkOutput("t1 rd_ch", rdCh, 2);
    checkOutput("t1 rd_data", rdData, 32'hDEADBEEF);
    checkOutput("t1 rd_ts", rdTs, expTs(5));
    checkOutput("t1 count", count, 1);
    tick(1);
    checkOutput("t1 popped", count, 0);
    rdReady = 1'b0;

    // All channels at once: drained in channel order.
    pulseClear();
    applyStimulus(4'b1111, packData(32'h10, 32'h11, 32'h12, 32'h13));
    tick(4);
    checkOutput("t2 count", count, 4);
    checkOutput("t2 drop", dropCnt, 0);
    rdReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("t2 order ch", rdCh, i);
      checkOutput("t2 order data", rdData, 32'h10 + i);
      tick(1);
    end
    rdReady = 1'b0;
    checkOutput("t2 empty", count, 0);

    // ch0 pulsed three times while ch1..3 hold the arbiter.
    pulseClear();
    applyStimulus(4'b1110, packData(0, 32'hB1, 32'hB2, 32'hB3));
    applyStimulus(4'b0001, packData(32'hA0, 0, 0, 0));
    applyStimulus(4'b0001, packData(32'hA1, 0, 0, 0));
    applyStimulus(4'b0001, packData(32'hA2, 0, 0, 0));
    tick(1);
    checkOutput("t3 count", count, 4);
    checkOutput("t3 drop", dropCnt, 2);
    rdReady = 1'b1;
    checkOutput("t3 rec0", {rdCh, rdData}, {2'd1, 32'hB1}); tick(1);
    checkOutput("t3 rec1", {rdCh, rdData}, {2'd2, 32'hB2}); tick(1);
    checkOutput("t3 rec2", {rdCh, rdData}, {2'd3, 32'hB3}); tick(1);
    checkOutput("t3 rec3", {rdCh, rdData}, {2'd0, 32'hA0}); tick(1);
    rdReady = 1'b0;

    // Stop mode: 20 events on ch1 with no reads.
    pulseClear();
    wrapMode = 1'b0;
    for (int i = 0; i < 20; i++) applyStimulus(4'b0010, packData(0, i, 0, 0));
    checkOutput("t4 count", count, 16);
    checkOutput("t4 drop", dropCnt, 3);
    checkOutput("t4 wrapped", wrapped, 0);
    rdReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput("t4 retained", rdData, i);
      tick(1);
    end
    checkOutput("t4 pending slot", rdData, 16);
    tick(2);
    rdReady = 1'b0;

    // Wrap mode: 20 events overwrite the oldest four.
    pulseClear();
    wrapMode = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus(4'b1000, packData(0, 0, 0, i));
    tick(1);
    checkOutput("t5 count", count, 16);
    checkOutput("t5 wrapped", wrapped, 1);
    checkOutput("t5 drop", dropCnt, 0);
    checkOutput("t5 oldest", rdData, 4);
    // Full with a push and a pop together: no extra overwrite.
    applyStimulus(4'b1000, packData(0, 0, 0, 20));
    rdReady = 1'b1;
    tick(1);
    checkOutput("t5 full pop+push count", count, 16);
    for (int i = 5; i <= 20; i++) begin
      checkOutput("t5 drained", rdData, i);
      tick(1);
    end
    rdReady = 1'b0;
    wrapMode = 1'b0;

    // Clear with seven records stored and events arriving in the same cycle.
    pulseClear();
    applyStimulus(4'b1111, packData(32'h20, 32'h21, 32'h22, 32'h23));
    applyStimulus(4'b0111, packData(32'h30, 32'h31, 32'h32, 0));
    tick(5);
    applyStimulus(4'b0011, packData(32'h40, 32'h41, 0, 0));
    tick(4);
    checkOutput("t6 count before", count, 7);
    checkOutput("t6 drop before", dropCnt, 2);
    clear = 1'b1;
    applyStimulus(4'b1111, packData(1, 2, 3, 4));
    clear = 1'b0;
    checkOutput("t6 count", count, 0);
    checkOutput("t6 rd_valid", rdValid, 0);
    checkOutput("t6 drop", dropCnt, 0);
    tick(3);
    checkOutput("t6 events discarded", count, 0);
    applyStimulus(4'b0010, packData(0, 32'h55, 0, 0));
    tick(1);
    checkOutput("t6 post-clear record", rdData, 32'h55);

    // Disabled capture, then reset mid-stream.
    pulseClear();
    enable = 1'b0;
    applyStimulus(4'b1111, packData(1, 2, 3, 4));
    tick(3);
    checkOutput("t7 disabled count", count, 0);
    checkOutput("t7 disabled drop", dropCnt, 0);
    enable = 1'b1;
    applyStimulus(4'b1111, packData(5, 6, 7, 8));
    applyStimulus(4'b0011, packData(9, 10, 0, 0));
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("t7 reset rd_valid", rdValid, 0);
    checkOutput("t7 reset drop", dropCnt, 0);
    tick(4);
    checkOutput("t7 reset discarded", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
